// File: rtl/grs_pkg.sv
// grs_pkg: shared widths, shift tables, FSM states and AES S-box
// for the Grostl-1024 round sequencer.
package grs_pkg;

  localparam int STATE_W = 1024;
  localparam int COLS    = 16;
  localparam int ROWS    = 8;

  localparam logic [3:0] SHIFT_P [ROWS] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd11
  };
  localparam logic [3:0] SHIFT_Q [ROWS] = '{
    4'd1, 4'd3, 4'd5, 4'd11, 4'd0, 4'd2, 4'd4, 4'd6
  };

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT0,
    WAIT,
    DONE
  } state_e;

  localparam logic [7:0] SBOX_T [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return SBOX_T[x];
  endfunction

endpackage

// File: rtl/grs_round_seq_if.sv
// grs_round_seq_if: request/result handshakes plus the
// MixBytes loop (mix_out / mix_in) of the round sequencer.
interface grs_round_seq_if;
  import grs_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_q;
  logic [STATE_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic [STATE_W-1:0] mix_out;
  logic [STATE_W-1:0] mix_in;

  modport master (
    output in_valid, in_q, in_data,
    output out_ready, mix_in,
    input  in_ready, out_valid,
    input  out_data, mix_out
  );

  modport slave (
    input  in_valid, in_q, in_data,
    input  out_ready, mix_in,
    output in_ready, out_valid,
    output out_data, mix_out
  );

endinterface

// File: rtl/grs_sbox.sv
// grs_sbox: one combinational AES S-box byte lookup.
module grs_sbox
  import grs_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = aes_sbox(a);

endmodule

// File: rtl/grs_round_seq.sv
// grs_round_seq: Grostl-1024 P/Q round sequencer (ARC, SubBytes, ShiftBytes).
// Define GRS_SBOX_REG_EN to register the ShiftBytes result (3-cycle rounds).
module grs_round_seq
  import grs_pkg::*;
#(
  parameter int ROUNDS = 14
) (
  input logic            clk,
  input logic            rst,
  grs_round_seq_if.slave bus
);

  localparam logic [3:0] RLAST = 4'(ROUNDS - 1);

  state_e             st_q, st_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic [3:0]         r_q, r_d;
  logic               q_q, q_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [STATE_W-1:0] arc, sub;
  logic [STATE_W-1:0] shf_p, shf_q, shf;

  // Byte (col j, row i) sits at bit STATE_W-1-8*(8j+i).
  for (genvar j = 0; j < COLS; j++) begin : g_col
    for (genvar i = 0; i < ROWS; i++) begin : g_row
      localparam int B  = STATE_W - 1 - 8 * (j * ROWS + i);
      localparam int JP = (j + int'(SHIFT_P[i])) % COLS;
      localparam int JQ = (j + int'(SHIFT_Q[i])) % COLS;
      localparam int BP = STATE_W - 1 - 8 * (JP * ROWS + i);
      localparam int BQ = STATE_W - 1 - 8 * (JQ * ROWS + i);
      logic [7:0] k;
      if (i == 0) begin : g_k0
        assign k = q_q ? 8'hff : {4'(j), r_q};
      end else if (i == ROWS - 1) begin : g_k7
        assign k = q_q ? (8'hff ^ {4'(j), r_q}) : 8'h00;
      end else begin : g_kx
        assign k = q_q ? 8'hff : 8'h00;
      end
      assign arc[B -: 8] = s_q[B -: 8] ^ k;
      grs_sbox u_sbox (
        .a (arc[B -: 8]),
        .y (sub[B -: 8])
      );
      assign shf_p[B -: 8] = sub[BP -: 8];
      assign shf_q[B -: 8] = sub[BQ -: 8];
    end
  end

  assign shf = q_q ? shf_q : shf_p;

`ifdef GRS_SBOX_REG_EN
  logic [STATE_W-1:0] sreg_q, sreg_d;
  assign bus.mix_out = sreg_q;
`else
  assign bus.mix_out = (st_q == ISSUE) ? shf : '0;
`endif

  always_comb begin
    st_d  = st_q;
    s_d   = s_q;
    r_d   = r_q;
    q_d   = q_q;
    out_d = out_q;
`ifdef GRS_SBOX_REG_EN
    sreg_d = (st_q == ISSUE) ? shf : '0;
`endif
    unique case (st_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d  = bus.in_data;
          q_d  = bus.in_q;
          r_d  = '0;
          st_d = ISSUE;
        end
      end
`ifdef GRS_SBOX_REG_EN
      ISSUE: st_d = WAIT0;
      WAIT0: st_d = WAIT;
`else
      ISSUE: st_d = WAIT;
`endif
      WAIT: begin
        s_d = bus.mix_in;
        if (r_q == RLAST) begin
          out_d = bus.mix_in;
          st_d  = DONE;
        end else begin
          r_d  = r_q + 4'd1;
          st_d = ISSUE;
        end
      end
      DONE: begin
        if (bus.out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    in_ready_d  = (st_d == IDLE);
    out_valid_d = (st_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      s_q         <= '0;
      out_q       <= '0;
      r_q         <= '0;
      q_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef GRS_SBOX_REG_EN
      sreg_q      <= '0;
`endif
    end else begin
      st_q        <= st_d;
      s_q         <= s_d;
      out_q       <= out_d;
      r_q         <= r_d;
      q_q         <= q_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef GRS_SBOX_REG_EN
      sreg_q      <= sreg_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_grs_round_seq.sv
// tb_grs_round_seq: random P/Q permutations against a behavioural
// Grostl model with a looped-back MixBytes register.
module tb_grs_round_seq;

  localparam int ROUNDS = 14;
`ifdef GRS_SBOX_REG_EN
  localparam int RCYC = 3;
  localparam int MOFS = 1;
`else
  localparam int RCYC = 2;
  localparam int MOFS = 0;
`endif
  localparam int PS [8] = '{0, 1, 2, 3, 4, 5, 6, 11};
  localparam int QS [8] = '{1, 3, 5, 11, 0, 2, 4, 6};
  localparam int MC [8] = '{2, 2, 3, 4, 5, 3, 5, 7};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grs_round_seq_if bus ();
  logic [1023:0] mix_reg;

  grs_round_seq #(.ROUNDS(ROUNDS)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] sb [256];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // S-box from GF(2^8) inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv, b1, b2, b3, b4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b1 = rol1(inv);
      b2 = rol1(b1);
      b3 = rol1(b2);
      b4 = rol1(b3);
      sb[x] = inv ^ b1 ^ b2 ^ b3 ^ b4 ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input logic [1023:0] v,
                                    input int j, input int i);
    return v[1023 - 8 * (8 * j + i) -: 8];
  endfunction

  function automatic logic [1023:0] rnd(input logic [1023:0] v,
                                        input int r, input bit q);
    logic [7:0] t [16][8];
    logic [7:0] b;
    logic [1023:0] o;
    int sh;
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 8; i++) begin
        b = gb(v, j, i);
        if (q) b ^= 8'hff;
        if ((!q && i == 0) || (q && i == 7))
          b ^= 8'((j << 4) ^ r);
        t[j][i] = sb[b];
      end
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 8; i++) begin
        sh = q ? QS[i] : PS[i];
        o[1023 - 8 * (8 * j + i) -: 8] = t[(j + sh) % 16][i];
      end
    return o;
  endfunction

  function automatic logic [1023:0] mixb(input logic [1023:0] v);
    logic [1023:0] o;
    logic [7:0] acc;
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 8; i++) begin
        acc = 8'h00;
        for (int k = 0; k < 8; k++)
          acc ^= gmul(8'(MC[k]), gb(v, j, (i + k) % 8));
        o[1023 - 8 * (8 * j + i) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [1023:0] perm(input logic [1023:0] v,
                                         input bit q);
    for (int r = 0; r < ROUNDS; r++) v = mixb(rnd(v, r, q));
    return v;
  endfunction

  function automatic logic [1023:0] rand_st();
    logic [1023:0] v = '0;
    for (int k = 0; k < 32; k++) v = {v[991:0], 32'($urandom())};
    return v;
  endfunction

  always @(posedge clk) mix_reg <= mixb(bus.mix_out);
  assign bus.mix_in = mix_reg;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wide compare reports the first differing column.
  task automatic check_st(input string tag, input logic [1023:0] got,
                          input logic [1023:0] exp);
    int c = 0;
    for (int j = 15; j >= 0; j--)
      if (got[1023 - 64 * j -: 64] !== exp[1023 - 64 * j -: 64]) c = j;
    check($sformatf("%s.col%0d", tag, c),
          got[1023 - 64 * c -: 64], exp[1023 - 64 * c -: 64]);
  endtask

  task automatic start(input logic [1023:0] d, input logic q);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_q     = q;
    bus.in_data  = d;
    check("acc_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [1023:0] exp,
                           input int n0);
    int n = n0;
    while (!bus.out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, 64'(n), 64'(RCYC * ROUNDS));
    check({tag, ".busy"}, 64'(bus.in_ready), 64'd0);
    check_st({tag, ".data"}, bus.out_data, exp);
  endtask

  task automatic release_out(input string tag, input logic [1023:0] exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".ov0"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".idle"}, 64'(bus.in_ready), 64'd1);
    check_st({tag, ".keep"}, bus.out_data, exp);
  endtask

  initial begin
    logic [1023:0] d, e, d2, got_a;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_q      = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_st("rst_out_data", bus.out_data, '0);
    check_st("rst_mix_out", bus.mix_out, '0);
    rst = 1'b0;

    start('0, 1'b0);
    repeat (MOFS) @(negedge clk);
    check("p0_c0", bus.mix_out[1023 -: 64], 64'h6363636363636363);
    check("p0_c1", bus.mix_out[959 -: 64], 64'hca63636363636363);
    check_st("p0_mix", bus.mix_out, rnd('0, 0, 1'b0));
    @(negedge clk);
    check_st("p0_mix_zero", bus.mix_out, '0);
    e = perm('0, 1'b0);
    wait_done("p0", e, MOFS + 1);
    release_out("p0", e);

    start('0, 1'b1);
    repeat (MOFS) @(negedge clk);
    check("q0_c0", bus.mix_out[1023 -: 64], 64'h16161616161616db);
    check_st("q0_mix", bus.mix_out, rnd('0, 0, 1'b1));
    e = perm('0, 1'b1);
    wait_done("q0", e, MOFS);
    release_out("q0", e);

    for (int t = 0; t < 4; t++) begin
      d = rand_st();
      e = perm(d, t[0]);
      start(d, t[0]);
      wait_done($sformatf("rnd%0d", t), e, 0);
      if (t == 2) begin
        for (int c = 0; c < 10; c++) begin
          bus.in_valid = c[0];
          bus.in_q     = c[1];
          bus.in_data  = rand_st();
          @(negedge clk);
          check("stall_ov", 64'(bus.out_valid), 64'd1);
          check("stall_ir", 64'(bus.in_ready), 64'd0);
          check_st("stall_data", bus.out_data, e);
        end
        bus.in_valid = 1'b0;
      end
      release_out($sformatf("rnd%0d", t), e);
    end

    d = rand_st();
    start(d, 1'b0);
    repeat (RCYC * 7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ir", 64'(bus.in_ready), 64'd1);
    check("mid_rst_ov", 64'(bus.out_valid), 64'd0);
    check_st("mid_rst_mix", bus.mix_out, '0);
    check_st("mid_rst_od", bus.out_data, '0);
    rst = 1'b0;
    d = rand_st();
    e = perm(d, 1'b1);
    start(d, 1'b1);
    wait_done("post_rst", e, 0);
    release_out("post_rst", e);

    d  = rand_st();
    d2 = rand_st();
    bus.out_ready = 1'b1;
    start(d, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_q     = 1'b1;
    bus.in_data  = d2;
    n = 0;
    got_a = '0;
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) got_a = bus.out_data;
    end
    check("b2b_gap", 64'(n + 1), 64'(RCYC * ROUNDS + 2));
    check_st("b2b_a", got_a, perm(d, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("b2b_b", perm(d2, 1'b1), 0);
    bus.out_ready = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
